// File: rtl/tick_sequencer.sv
// tick_sequencer: programmable burst tick generator with start/stop handshake.
// Define TICK_SEQ_CONTINUOUS_EN to accept burst==0 as an endless tick stream.
module tick_sequencer #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [CNT_W-1:0]   period_i,
    input  logic [BURST_W-1:0] burst_i,
    output logic               busy_o,
    output logic               tick_o,
    output logic               done_o,
    output logic [BURST_W-1:0] ticks_left_o
);
`ifdef TICK_SEQ_CONTINUOUS_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d;
    logic [BURST_W-1:0] left_q, left_d;
    logic               cont_q, cont_d, busy_q, busy_d, tick_q, tick_d, done_q, done_d;
    logic               accept, terminal;

    assign accept   = (period_i != '0) && ((burst_i != '0) || CONT_EN);
    assign terminal = (cnt_q == period_q - CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        left_d   = left_q;
        cont_d   = cont_q;
        busy_d   = busy_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (start_i && !stop_i) begin
                if (accept) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    period_d = period_i;
                    left_d   = burst_i;
                    cont_d   = (burst_i == '0);
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (stop_i) begin
            // Stop takes priority over a coincident terminal count.
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
            left_d  = '0;
        end else if (terminal) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (!cont_q) begin
                left_d = left_q - BURST_W'(1);
                if (left_q == BURST_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            left_q   <= '0;
            cont_q   <= 1'b0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            left_q   <= left_d;
            cont_q   <= cont_d;
            busy_q   <= busy_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign busy_o       = busy_q;
    assign tick_o       = tick_q;
    assign done_o       = done_q;
    assign ticks_left_o = left_q;
endmodule

// File: tb/tb_tick_sequencer.sv
// tb_tick_sequencer: randomized and directed checks against an arithmetic burst model.
module tb_tick_sequencer;
`ifdef TICK_SEQ_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start = 1'b0, stop = 1'b0;
    logic [7:0] period = '0, burst = '0;
    logic       busy, tick, done;
    logic [7:0] ticks_left;

    tick_sequencer #(.CNT_W(8), .BURST_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .stop_i(stop),
        .period_i(period), .burst_i(burst), .busy_o(busy), .tick_o(tick),
        .done_o(done), .ticks_left_o(ticks_left)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    // Reference: a burst started at edge s with period P ticks at edges s+P*j, j=1..B.
    int n = 0, s = 0, p = 0, b = 0;
    bit act = 0;
    bit e_tick = 0, e_done = 0;
    int e_left = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge(input bit st, input bit sp, input int per, input int bur);
        int k;
        n++;
        e_tick = 0;
        e_done = 0;
        if (act) begin
            k = n - s;
            if (sp) begin
                act = 0;
                e_left = 0;
            end else if (k % p == 0) begin
                e_tick = 1;
                if (b != 0) begin
                    e_left = b - k / p;
                    if (e_left == 0) begin
                        e_done = 1;
                        act = 0;
                    end
                end
            end
        end else if (st && !sp) begin
            if (per >= 1 && (bur >= 1 || CONT)) begin
                act = 1;
                s = n;
                p = per;
                b = bur;
                e_left = bur;
            end else begin
                e_done = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".tick"}, int'(tick), int'(e_tick));
        check({tag, ".done"}, int'(done), int'(e_done));
        check({tag, ".busy"}, int'(busy), int'(act));
        check({tag, ".left"}, int'(ticks_left), e_left);
    endtask

    task automatic step(input bit st, input bit sp, input int per, input int bur, input string tag);
        start  = st;
        stop   = sp;
        period = 8'(per);
        burst  = 8'(bur);
        @(posedge clk);
        model_edge(st, sp, per, bur);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst_ni = 1'b0;
        #1;
        act = 0;
        e_tick = 0;
        e_done = 0;
        e_left = 0;
        compare_all(tag);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        #2;
        compare_all("reset");
        @(negedge clk);
        rst_ni = 1'b1;
        step(1, 0, 5, 3, "p5b3");
        idle(18, "p5b3");
        step(1, 0, 1, 4, "p1b4");
        idle(6, "p1b4");
        step(1, 0, 0, 3, "rej_p0");
        idle(2, "rej_p0");
        step(1, 0, 4, 0, "burst0");
        idle(10, "burst0");
        step(0, 1, 0, 0, "burst0_stop");
        step(1, 1, 4, 2, "start_stop");
        idle(2, "start_stop");
        step(1, 0, 5, 10, "stop2");
        idle(9, "stop2");
        step(0, 1, 0, 0, "stop2_edge");
        idle(3, "stop2");
        step(1, 0, 4, 2, "mid");
        idle(2, "mid");
        step(1, 0, 3, 5, "mid_start");
        idle(5, "mid");
        step(1, 0, 2, 2, "b2b");
        idle(6, "b2b");
        step(1, 0, 3, 6, "rst_mid");
        idle(5, "rst_mid");
        pulse_reset("rst_mid");
        idle(3, "post_rst");
        if (CONT) begin
            step(1, 0, 4, 0, "cont");
            idle(50, "cont");
            step(0, 1, 0, 0, "cont_stop");
            idle(8, "cont_after");
        end
        for (int i = 0; i < 3000; i++) begin
            bit st, sp;
            int per, bur;
            st  = ($urandom_range(0, 5) == 0);
            sp  = ($urandom_range(0, 29) == 0);
            per = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            bur = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            step(st, sp, per, bur, "rand");
            if ($urandom_range(0, 999) == 0) pulse_reset("rand_rst");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tick_sequencer.md
Name: tick_sequencer

Overview:
- Programmable controller for a divide-by-N pulse generator. Emits a burst of single-cycle ticks spaced PERIOD cycles apart, then signals completion.
- Sits between the iteration control FSM and the datapath stages that need a periodic strobe.
- Replaces fixed divide-by-5 pulse logic with a runtime period, a burst length, a start/stop handshake and status outputs.

Parameters:
- CNT_W, 8, width of the period operand and internal cycle counter
- BURST_W, 8, width of the burst-length operand and ticks_left counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a burst, sampled on rising clk
- stop  in  1  abort request, sampled on rising clk
- period  in  CNT_W  cycles between ticks, sampled only when start is accepted
- burst  in  BURST_W  number of ticks in the burst, sampled only when start is accepted
- busy  out  1  high while a burst is in progress
- tick  out  1  one-cycle strobe, one per period
- done  out  1  one-cycle pulse when a burst completes or a start is rejected
- ticks_left  out  BURST_W  ticks still to be issued in the current burst

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy=0, tick=0, done=0, ticks_left=0; internal counter=0. Reset mid-burst aborts immediately; no done is issued.
- All outputs are registered.
- States: IDLE, RUN.
- IDLE, start=1, stop=0, period>=1, burst>=1:
  - Latch period_q=period and ticks_left=burst; counter=0.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1 with period==0 or burst==0: no transition, no tick; done=1 for one cycle (reject).
- IDLE, start=1 and stop=1 together: stop wins; request ignored, no done.
- RUN, each cycle: counter increments.
  - When counter==period_q-1: counter returns to 0, tick=1 the following cycle, and ticks_left decrements at that same edge.
  - Otherwise tick=0.
- Latency:
  - Start sampled at edge E. The first tick is high in the cycle following edge E+period_q.
  - Later ticks follow every period_q cycles.
  - period_q=1 gives a tick every cycle.
- Final tick (ticks_left==1 at the terminal count):
  - At the same edge: tick=1, done=1, busy=0, ticks_left=0, state=IDLE.
  - A start in the next cycle is accepted (back-to-back bursts allowed).
- RUN, stop=1: at the next edge go to IDLE, busy=0, tick=0, ticks_left=0, no done. Stop beats a coincident terminal count.
- start while busy=1 is ignored. period and burst changes during RUN are ignored.
- The counter never exceeds period_q-1. No wrap beyond the CNT_W range is possible.

Optional Feature:
- Macro: TICK_SEQ_CONTINUOUS_EN.
- Defined: burst==0 at start (with period>=1) is accepted as continuous mode.
  - Ticks are issued every period_q cycles indefinitely.
  - ticks_left holds 0; done never asserts.
  - Only stop or reset ends the burst; stop behaves as in RUN.
- Not defined: burst==0 is rejected with a one-cycle done, as above.
- No other behaviour differs.

Test Plan:
- Reset released, start with period=5, burst=3 at edge 0 -> ticks in the cycles after edges 5, 10 and 15; done and busy=0 coincide with the third tick; ticks_left steps 3,2,1,0.
- period=1, burst=4 -> four consecutive tick cycles; done on the fourth; busy high for exactly 4 cycles.
- start with period=0, or with burst=0 and the macro undefined -> no tick, busy stays 0, done high for one cycle.
- period=5, burst=10; stop asserted on the cycle of the 2nd terminal count -> no 2nd tick, no done, busy=0 next cycle, ticks_left=0.
- Start mid-burst with period=3 -> ignored, original timing kept; start on the cycle after done -> new burst accepted; rst pulsed low mid-burst -> all outputs 0 immediately.
- Macro defined, period=4, burst=0 -> tick every 4 cycles for 50 cycles with no done; stop -> busy=0, ticks cease.
